// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch front end. Drives a synchronous ROM with a
//                fetch PC, tracks one outstanding read, and buffers results
//                in a 2-entry FIFO toward decode. Handles redirects,
//                misaligned/out-of-range fetch faults (with HALT) and
//                downstream back-pressure without losing or reordering entries.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ROM_DEPTH = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] o_rom_pc,
  input  logic [31:0] i_rom_insn,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_insn,
  output logic        o_fault
);

  localparam logic [0:0]  c_RUN       = 1'b0;
  localparam logic [0:0]  c_HALT      = 1'b1;
  localparam logic [31:0] c_NOP       = 32'h0000_0013;
  // Byte size of the ROM, one bit wider than a PC so the limit never wraps.
  localparam logic [32:0] c_ROM_LIMIT = 33'(ROM_DEPTH) << 2;

  logic [31:0] fpc_q, fpc_d;
  logic [0:0]  state_q, state_d;
  logic        inflight_q, inflight_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        req_fault_q, req_fault_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] fifo_pc_q    [2];
  logic [31:0] fifo_pc_d    [2];
  logic [31:0] fifo_insn_q  [2];
  logic [31:0] fifo_insn_d  [2];
  logic        fifo_fault_q [2];
  logic        fifo_fault_d [2];

  logic        w_pop;
  logic        w_push;
  logic        w_issue;
  logic        w_fault_new;
  logic [2:0]  w_credit;
  logic [1:0]  w_cnt_after_pop;
  logic [31:0] w_push_insn;

  // Handshake terms: pop/push this edge and whether a new read may be issued.
  always_comb begin
    w_pop           = (count_q != 2'd0) & ~i_stall;
    w_push          = inflight_q & ~i_redirect;
    // Occupancy once the current read lands, net of this cycle's pop; a new
    // read is only allowed if its result is guaranteed a free slot.
    w_credit        = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, w_pop};
    w_issue         = (state_q == c_RUN) & ~i_redirect & (w_credit <= 3'd1);
    w_fault_new     = (fpc_q[1:0] != 2'b00) | ({1'b0, fpc_q} >= c_ROM_LIMIT);
    w_cnt_after_pop = count_q - {1'b0, w_pop};
    w_push_insn     = req_fault_q ? c_NOP : i_rom_insn;
  end

  // Next-state computation for PC, request tracking, FSM and FIFO.
  always_comb begin
    fpc_d        = fpc_q;
    state_d      = state_q;
    inflight_d   = 1'b0;
    req_pc_d     = req_pc_q;
    req_fault_d  = req_fault_q;
    fifo_pc_d    = fifo_pc_q;
    fifo_insn_d  = fifo_insn_q;
    fifo_fault_d = fifo_fault_q;
    count_d      = w_cnt_after_pop + {1'b0, w_push};

    // Head removal shifts the second slot forward.
    if (w_pop) begin
      fifo_pc_d[0]    = fifo_pc_q[1];
      fifo_insn_d[0]  = fifo_insn_q[1];
      fifo_fault_d[0] = fifo_fault_q[1];
    end

    // Returning read lands in the first free slot after any pop.
    if (w_push) begin
      if (w_cnt_after_pop == 2'd0) begin
        fifo_pc_d[0]    = req_pc_q;
        fifo_insn_d[0]  = w_push_insn;
        fifo_fault_d[0] = req_fault_q;
      end else begin
        fifo_pc_d[1]    = req_pc_q;
        fifo_insn_d[1]  = w_push_insn;
        fifo_fault_d[1] = req_fault_q;
      end
    end

    // A faulting fetch is still delivered, then fetching stops.
    if (w_issue) begin
      inflight_d  = 1'b1;
      req_pc_d    = fpc_q;
      req_fault_d = w_fault_new;
      fpc_d       = fpc_q + 32'd4;
      if (w_fault_new) begin
        state_d = c_HALT;
      end
    end

    // Redirect overrides everything: flush and restart at the target.
    if (i_redirect) begin
      count_d    = 2'd0;
      inflight_d = 1'b0;
      fpc_d      = i_redirect_pc;
      state_d    = c_RUN;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc_q        <= RESET_PC;
      state_q      <= c_RUN;
      inflight_q   <= 1'b0;
      req_pc_q     <= 32'd0;
      req_fault_q  <= 1'b0;
      count_q      <= 2'd0;
      fifo_pc_q    <= '{default: '0};
      fifo_insn_q  <= '{default: '0};
      fifo_fault_q <= '{default: 1'b0};
    end else begin
      fpc_q        <= fpc_d;
      state_q      <= state_d;
      inflight_q   <= inflight_d;
      req_pc_q     <= req_pc_d;
      req_fault_q  <= req_fault_d;
      count_q      <= count_d;
      fifo_pc_q    <= fifo_pc_d;
      fifo_insn_q  <= fifo_insn_d;
      fifo_fault_q <= fifo_fault_d;
    end
  end

  // Output drive: FIFO head when valid, zeros otherwise.
  always_comb begin
    o_rom_pc = fpc_q;
    o_valid  = (count_q != 2'd0);
    o_pc     = o_valid ? fifo_pc_q[0]    : 32'd0;
    o_insn   = o_valid ? fifo_insn_q[0]  : 32'd0;
    o_fault  = o_valid ? fifo_fault_q[0] : 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit. A ROM model returns
//                A000_0000+word_index one cycle after the address; a program
//                order model tracks the expected next PC and checks every
//                presented entry, alongside directed latency/boundary checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] o_rom_pc;
  logic [31:0] rom_insn = 32'd0;
  logic        i_stall;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_valid;
  logic [31:0] o_pc;
  logic [31:0] o_insn;
  logic        o_fault;

  int n_checks = 0;
  int n_errors = 0;

  // Expected-stream model state
  logic [31:0] exp_pc = 32'd0;
  logic        halted = 1'b0;

  fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .o_rom_pc     (o_rom_pc),
    .i_rom_insn   (rom_insn),
    .i_stall      (i_stall),
    .i_redirect   (i_redirect),
    .i_redirect_pc(i_redirect_pc),
    .o_valid      (o_valid),
    .o_pc         (o_pc),
    .o_insn       (o_insn),
    .o_fault      (o_fault)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: word i holds A000_0000 + i (128 words).
  always @(posedge clk) rom_insn <= 32'hA000_0000 + ((o_rom_pc >> 2) & 32'd127);

  function automatic logic exp_fault(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc >= 32'd512);
  endfunction

  function automatic logic [31:0] exp_insn(input logic [31:0] pc);
    return exp_fault(pc) ? 32'h0000_0013 : (32'hA000_0000 + (pc >> 2));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Program-order model: check every presented entry, advance on accept.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", {31'd0, o_valid}, 32'd0);
      chk("rst_rom_pc", o_rom_pc, 32'd0);
      exp_pc = 32'd0;
      halted = 1'b0;
    end else begin
      if (halted) begin
        chk("halt_valid", {31'd0, o_valid}, 32'd0);
      end else if (o_valid) begin
        chk("pc", o_pc, exp_pc);
        chk("insn", o_insn, exp_insn(exp_pc));
        chk("fault", {31'd0, o_fault}, {31'd0, exp_fault(exp_pc)});
      end else begin
        chk("idle_out", o_pc | o_insn | {31'd0, o_fault}, 32'd0);
      end
      if (i_redirect) begin
        exp_pc = i_redirect_pc;
        halted = 1'b0;
      end else if (o_valid && !i_stall && !halted) begin
        if (exp_fault(exp_pc)) halted = 1'b1;
        exp_pc = exp_pc + 32'd4;
      end
    end
  end

  task automatic redirect_to(input logic [31:0] pc);
    i_redirect    = 1'b1;
    i_redirect_pc = pc;
    step;
    i_redirect    = 1'b0;
    i_redirect_pc = 32'd0;
  endtask

  logic [31:0] held_rom_pc;
  logic [31:0] stall_pat;

  initial begin
    rst_n = 1'b0; i_stall = 1'b0; i_redirect = 1'b0; i_redirect_pc = 32'd0;
    step; step;
    chk("reset_valid", {31'd0, o_valid}, 32'd0);
    chk("reset_pc", o_pc, 32'd0);
    chk("reset_insn", o_insn, 32'd0);
    chk("reset_fault", {31'd0, o_fault}, 32'd0);
    chk("reset_rom_pc", o_rom_pc, 32'd0);

    // Reset release: valid from the second edge, one entry per cycle.
    @(negedge clk); #1 rst_n = 1'b1;
    step; chk("fill1_valid", {31'd0, o_valid}, 32'd0);
    step; chk("fill2_valid", {31'd0, o_valid}, 32'd1);
    chk("first_pc", o_pc, 32'h0);
    chk("first_insn", o_insn, 32'hA000_0000);
    step; chk("second_pc", o_pc, 32'h4);
    chk("second_insn", o_insn, 32'hA000_0001);
    step; chk("third_pc", o_pc, 32'h8);
    step; step;

    // Stall for 5 cycles: FIFO fills, fetch PC stops advancing.
    i_stall = 1'b1;
    step; step;
    held_rom_pc = o_rom_pc;
    step; step; step;
    chk("stall_no_issue", o_rom_pc, held_rom_pc);
    chk("stall_valid", {31'd0, o_valid}, 32'd1);
    i_stall = 1'b0;
    repeat (4) step;

    // Redirect while stalled with two buffered entries.
    i_stall = 1'b1;
    step; step; step;
    redirect_to(32'h40);
    i_stall = 1'b0;
    chk("redir_t0_valid", {31'd0, o_valid}, 32'd0);
    step; chk("redir_t1_valid", {31'd0, o_valid}, 32'd0);
    step; chk("redir_t2_valid", {31'd0, o_valid}, 32'd1);
    chk("redir_pc", o_pc, 32'h40);
    chk("redir_insn", o_insn, 32'hA000_0010);
    repeat (3) step;

    // Run off the end of the ROM: last word, then fault, then HALT.
    redirect_to(32'h1FC);
    step;
    step; chk("end_pc", o_pc, 32'h1FC);
    chk("end_fault", {31'd0, o_fault}, 32'd0);
    chk("end_insn", o_insn, 32'hA000_007F);
    step; chk("oob_pc", o_pc, 32'h200);
    chk("oob_fault", {31'd0, o_fault}, 32'd1);
    chk("oob_insn", o_insn, 32'h0000_0013);
    step; chk("halt1_valid", {31'd0, o_valid}, 32'd0);
    repeat (3) step;
    chk("halt2_valid", {31'd0, o_valid}, 32'd0);

    // Misaligned target: single faulting entry, then HALT.
    redirect_to(32'h6);
    step;
    step; chk("mis_pc", o_pc, 32'h6);
    chk("mis_fault", {31'd0, o_fault}, 32'd1);
    chk("mis_insn", o_insn, 32'h0000_0013);
    step; chk("mis_halt_valid", {31'd0, o_valid}, 32'd0);
    step;

    // Irregular stall pattern stream; ordering checked by the model.
    redirect_to(32'h0);
    stall_pat = 32'b0110_1110_0010_1111_0001_1011_0100_1100;
    for (int i = 0; i < 32; i++) begin
      i_stall = stall_pat[i];
      step;
    end
    i_stall = 1'b0;
    repeat (3) step;

    // Asynchronous reset mid-stream.
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, o_valid}, 32'd0);
    chk("async_rst_rom_pc", o_rom_pc, 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    step; chk("restart1_valid", {31'd0, o_valid}, 32'd0);
    step; chk("restart2_pc", o_pc, 32'h0);
    chk("restart2_valid", {31'd0, o_valid}, 32'd1);
    repeat (4) step;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
